// File: rtl/cms_ctrl_sequencer_pkg.sv
// Shared types and constants for the monitor control-write sequencer:
// control address map, request payload, sequencer FSM states and widths.
package cms_ctrl_sequencer_pkg;

  localparam int unsigned CTRL_ADDR_WIDTH = 4;
  localparam int unsigned CTRL_DATA_WIDTH = 32;
  localparam int unsigned CTRL_ADDR_COUNT = 2 ** CTRL_ADDR_WIDTH;

  typedef logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr_t;

  localparam ctrl_addr_t CLK_COUNTER                         = 4'd0;
  localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_LOWER_BOUND = 4'd1;
  localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_UPPER_BOUND = 4'd2;
  localparam ctrl_addr_t TRIGGER_TRACE_START_ADDRESS         = 4'd3;
  localparam ctrl_addr_t TRIGGER_TRACE_END_ADDRESS           = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } cms_ctrl_seq_state_t;

  localparam int unsigned CMS_CTRL_SEQ_TIMER_WIDTH  = 8;
  localparam int unsigned CMS_CTRL_SEQ_ISSUED_WIDTH = 16;

  typedef struct packed {
    ctrl_addr_t                 addr;
    logic [CTRL_DATA_WIDTH-1:0] wdata;
  } cms_ctrl_req_t;

  // Upper-bound style registers power up as "match everything" (all ones).
  function automatic logic [CTRL_DATA_WIDTH-1:0] shadow_reset_value(input ctrl_addr_t addr);
    if (addr == MONITORED_ADDRESS_RANGE_UPPER_BOUND || addr == TRIGGER_TRACE_END_ADDRESS) begin
      return '1;
    end
    return '0;
  endfunction

endpackage

// File: rtl/cms_ctrl_seq_fifo.sv
// Synchronous first-word-fall-through FIFO holding pending control writes;
// flush empties it in one cycle.
module cms_ctrl_seq_fifo
  import cms_ctrl_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cms_ctrl_sequencer.sv
// Replays queued control writes onto the monitor control port as timed
// write-enable pulses. Optional shadow readback: CMS_CTRL_SEQ_SHADOW_EN.
module cms_ctrl_sequencer
  import cms_ctrl_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  ctrl_addr_t                               req_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]               req_wdata,
  input  logic                                     flush,
  output ctrl_addr_t                               ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0]               ctrl_wdata,
  output logic                                     ctrl_write_enable,
  output logic                                     busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]          fifo_count,
  output logic [CMS_CTRL_SEQ_ISSUED_WIDTH-1:0]     issued_count
`ifdef CMS_CTRL_SEQ_SHADOW_EN
  ,
  input  ctrl_addr_t                               shadow_raddr,
  output logic [CTRL_DATA_WIDTH-1:0]               shadow_rdata
`endif
);

  localparam int unsigned TW = CMS_CTRL_SEQ_TIMER_WIDTH;
  localparam int unsigned RW = $bits(cms_ctrl_req_t);
  localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "cms_ctrl_sequencer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
    $fatal(1, "cms_ctrl_sequencer: SETUP_CYCLES must be 1..255");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 255) begin : g_bad_pulse
    $fatal(1, "cms_ctrl_sequencer: PULSE_CYCLES must be 1..255");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $fatal(1, "cms_ctrl_sequencer: GAP_CYCLES must be 1..255");
  end

  cms_ctrl_seq_state_t state;
  logic [TW-1:0]       timer;
  cms_ctrl_req_t       push_req;
  cms_ctrl_req_t       head_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                timer_done;
  logic                raise;

  assign push_req   = '{addr: req_addr, wdata: req_wdata};
  assign req_ready  = ~fifo_full & ~flush;
  assign fifo_push  = req_valid & req_ready;
  // Flush in IDLE suppresses the pop so nothing from the discarded queue starts.
  assign fifo_pop   = (state == IDLE) & ~fifo_empty & ~flush;
  assign timer_done = (timer == '0);
  assign raise      = (state == SETUP) & timer_done;
  assign busy       = (state != IDLE) | ~fifo_empty;

  cms_ctrl_seq_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata (push_req),
    .head  (head_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencer: addr/data latched at pop and held until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      timer             <= '0;
      ctrl_addr         <= '0;
      ctrl_wdata        <= '0;
      ctrl_write_enable <= 1'b0;
      issued_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            ctrl_addr  <= head_req.addr;
            ctrl_wdata <= head_req.wdata;
            timer      <= SETUP_LOAD;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (timer_done) begin
            ctrl_write_enable <= 1'b1;
            timer             <= PULSE_LOAD;
            state             <= PULSE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        PULSE: begin
          if (timer_done) begin
            ctrl_write_enable <= 1'b0;
            issued_count      <= issued_count + CMS_CTRL_SEQ_ISSUED_WIDTH'(1);
            timer             <= GAP_LOAD;
            state             <= GAP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: begin
          if (timer_done) begin
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CMS_CTRL_SEQ_SHADOW_EN
  logic [CTRL_DATA_WIDTH-1:0] shadow [CTRL_ADDR_COUNT];

  // Shadow captures the value the monitor sees on the enable's rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CTRL_ADDR_COUNT); i++) begin
        shadow[i] <= shadow_reset_value(CTRL_ADDR_WIDTH'(i));
      end
    end else if (raise) begin
      shadow[ctrl_addr] <= ctrl_wdata;
    end
  end

  assign shadow_rdata = shadow[shadow_raddr];
`else
  logic unused_raise;
  assign unused_raise = raise;
`endif

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Self-checking bench for cms_ctrl_sequencer: three instances with different
// timing, a per-edge timing model, directed tables and random traffic.
`timescale 1ns/1ps
module tb_cms_ctrl_sequencer;
  import cms_ctrl_sequencer_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     flush;
  logic [N-1:0]     wen;
  logic [N-1:0]     busy;
  ctrl_addr_t       req_addr     [N];
  logic [31:0]      req_wdata    [N];
  ctrl_addr_t       ctrl_addr    [N];
  logic [31:0]      ctrl_wdata   [N];
  logic [CNT_W-1:0] fifo_count   [N];
  logic [15:0]      issued_count [N];
`ifdef CMS_CTRL_SEQ_SHADOW_EN
  ctrl_addr_t       shadow_raddr [N];
  logic [31:0]      shadow_rdata [N];
`endif

  always #5 clk = ~clk;

  cms_ctrl_sequencer #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .flush(flush[0]),
    .ctrl_addr(ctrl_addr[0]), .ctrl_wdata(ctrl_wdata[0]), .ctrl_write_enable(wen[0]),
    .busy(busy[0]), .fifo_count(fifo_count[0]), .issued_count(issued_count[0])
`ifdef CMS_CTRL_SEQ_SHADOW_EN
    , .shadow_raddr(shadow_raddr[0]), .shadow_rdata(shadow_rdata[0])
`endif
  );

  cms_ctrl_sequencer #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(4), .PULSE_CYCLES(4), .GAP_CYCLES(4)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .flush(flush[1]),
    .ctrl_addr(ctrl_addr[1]), .ctrl_wdata(ctrl_wdata[1]), .ctrl_write_enable(wen[1]),
    .busy(busy[1]), .fifo_count(fifo_count[1]), .issued_count(issued_count[1])
`ifdef CMS_CTRL_SEQ_SHADOW_EN
    , .shadow_raddr(shadow_raddr[1]), .shadow_rdata(shadow_rdata[1])
`endif
  );

  cms_ctrl_sequencer #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(2), .PULSE_CYCLES(3), .GAP_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .flush(flush[2]),
    .ctrl_addr(ctrl_addr[2]), .ctrl_wdata(ctrl_wdata[2]), .ctrl_write_enable(wen[2]),
    .busy(busy[2]), .fifo_count(fifo_count[2]), .issued_count(issued_count[2])
`ifdef CMS_CTRL_SEQ_SHADOW_EN
    , .shadow_raddr(shadow_raddr[2]), .shadow_rdata(shadow_rdata[2])
`endif
  );

  function automatic int s_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 2;
  endfunction
  function automatic int p_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 3;
  endfunction
  function automatic int g_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 2;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending queue plus the edge number of the current pop.
  typedef struct {
    int          inst;
    ctrl_addr_t  addr;
    logic [31:0] data;
  } ent_t;
  ent_t        mq[$];
  int          cyc = 0;
  bit          m_active [N];
  int          m_pop    [N];
  ctrl_addr_t  m_addr   [N];
  logic [31:0] m_data   [N];
  logic [15:0] m_issued [N];

  typedef struct {
    int          inst;
    int          cyc;
    bit          rise;
    logic [31:0] data;
  } ev_t;
  ev_t  evq[$];
  logic [N-1:0] prev_en = '0;

  function automatic int qcount(input int i);
    int n = 0;
    foreach (mq[k]) if (mq[k].inst == i) n++;
    return n;
  endfunction

  task automatic model_step();
    cyc++;
    for (int i = 0; i < N; i++) begin
      int  sz;
      bit  acc;
      sz  = qcount(i);
      acc = req_valid[i] && (sz < DEPTH) && !flush[i];
      if (rst) begin
        m_active[i] = 1'b0;
        m_addr[i]   = '0;
        m_data[i]   = '0;
        m_issued[i] = '0;
        for (int k = mq.size() - 1; k >= 0; k--) if (mq[k].inst == i) mq.delete(k);
        continue;
      end
      if (!m_active[i]) begin
        if (sz > 0 && !flush[i]) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].inst == i) begin
              m_addr[i] = mq[k].addr;
              m_data[i] = mq[k].data;
              mq.delete(k);
              break;
            end
          end
          m_pop[i]    = cyc;
          m_active[i] = 1'b1;
        end
      end else begin
        if (cyc == m_pop[i] + s_of(i) + p_of(i)) m_issued[i] = m_issued[i] + 16'd1;
        if (cyc == m_pop[i] + s_of(i) + p_of(i) + g_of(i)) m_active[i] = 1'b0;
      end
      if (flush[i]) begin
        for (int k = mq.size() - 1; k >= 0; k--) if (mq[k].inst == i) mq.delete(k);
      end
      if (acc) mq.push_back('{inst: i, addr: req_addr[i], data: req_wdata[i]});
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      bit exp_en;
      exp_en = m_active[i] && (cyc >= m_pop[i] + s_of(i)) && (cyc < m_pop[i] + s_of(i) + p_of(i));
      chk($sformatf("enable[%0d]@%0d", i, cyc), 64'(wen[i]), 64'(exp_en));
      chk($sformatf("ctrl_addr[%0d]@%0d", i, cyc), 64'(ctrl_addr[i]), 64'(m_addr[i]));
      chk($sformatf("ctrl_wdata[%0d]@%0d", i, cyc), 64'(ctrl_wdata[i]), 64'(m_data[i]));
      chk($sformatf("fifo_count[%0d]@%0d", i, cyc), 64'(fifo_count[i]), 64'(qcount(i)));
      chk($sformatf("issued[%0d]@%0d", i, cyc), 64'(issued_count[i]), 64'(m_issued[i]));
      chk($sformatf("busy[%0d]@%0d", i, cyc), 64'(busy[i]), 64'(m_active[i] || qcount(i) > 0));
      chk($sformatf("ready[%0d]@%0d", i, cyc), 64'(req_ready[i]),
          64'((qcount(i) < DEPTH) && !flush[i]));
      if (wen[i] != prev_en[i]) evq.push_back('{inst: i, cyc: cyc, rise: wen[i], data: ctrl_wdata[i]});
    end
    prev_en = wen;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    flush     = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst enable[%0d]", i), 64'(wen[i]), 64'd0);
      chk($sformatf("rst count[%0d]", i), 64'(fifo_count[i]), 64'd0);
      chk($sformatf("rst ready[%0d]", i), 64'(req_ready[i]), 64'd1);
      chk($sformatf("rst busy[%0d]", i), 64'(busy[i]), 64'd0);
    end
    evq.delete();
  endtask

  function automatic int ev_count(input int i, input bit rise);
    int n = 0;
    foreach (evq[k]) if (evq[k].inst == i && evq[k].rise == rise) n++;
    return n;
  endfunction

  typedef struct {
    int          inst;
    ctrl_addr_t  addr;
    logic [31:0] data;
    int          lat;
    int          width;
    int          idle_after;
  } vec_t;

  initial begin
    vec_t        vt [4];
    int          i;
    int          k;
    int          w;
    int          n_acc;
    bit          rdy;
    bit          full_seen;
    ctrl_addr_t  prev_addr;
    logic [31:0] prev_data;
    int          rises [$];
    int          falls [$];
    logic [31:0] rdata [$];

    rst       = 1'b1;
    req_valid = '0;
    flush     = '0;
    for (int j = 0; j < N; j++) begin
      req_addr[j]  = '0;
      req_wdata[j] = '0;
`ifdef CMS_CTRL_SEQ_SHADOW_EN
      shadow_raddr[j] = '0;
`endif
    end
    @(negedge clk);

    // Single requests: latency to rise, pulse width, return to idle.
    vt[0] = '{0, TRIGGER_TRACE_START_ADDRESS, 32'h8000_0000, 2, 1, 1};
    vt[1] = '{1, ctrl_addr_t'(9), 32'h1234_5678, 5, 4, 4};
    vt[2] = '{2, ctrl_addr_t'(6), 32'hdead_beef, 3, 3, 2};
    vt[3] = '{0, TRIGGER_TRACE_END_ADDRESS, 32'h0000_00ff, 2, 1, 1};
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      i = vt[r].inst;
      req_valid[i] = 1'b1;
      req_addr[i]  = vt[r].addr;
      req_wdata[i] = vt[r].data;
      tick();
      req_valid[i] = 1'b0;
      k = 0;
      prev_addr = '0;
      prev_data = '0;
      while (!wen[i] && k < 20) begin
        prev_addr = ctrl_addr[i];
        prev_data = ctrl_wdata[i];
        tick();
        k++;
      end
      chk($sformatf("row%0d rise latency", r), 64'(k), 64'(vt[r].lat));
      chk($sformatf("row%0d addr before rise", r), 64'(prev_addr), 64'(vt[r].addr));
      chk($sformatf("row%0d data before rise", r), 64'(prev_data), 64'(vt[r].data));
      w = 0;
      while (wen[i] && w < 300) begin
        tick();
        w++;
      end
      chk($sformatf("row%0d pulse width", r), 64'(w), 64'(vt[r].width));
      for (int j = 0; j < vt[r].idle_after - 1; j++) tick();
      chk($sformatf("row%0d busy in gap", r), 64'(busy[i]), 64'd1);
      tick();
      chk($sformatf("row%0d busy idle", r), 64'(busy[i]), 64'd0);
      chk($sformatf("row%0d issued", r), 64'(issued_count[i]), 64'd1);
    end

    // Twelve back-to-back pushes into the 4/4/4 instance.
    apply_reset();
    n_acc     = 0;
    full_seen = 1'b0;
    for (int t = 0; t < 300 && n_acc < 12; t++) begin
      req_valid[1] = 1'b1;
      req_addr[1]  = ctrl_addr_t'(n_acc);
      req_wdata[1] = 32'h100 + 32'(n_acc);
      #1;
      rdy = req_ready[1];
      if (!rdy && !full_seen) begin
        full_seen = 1'b1;
        chk("ready falls at full", 64'(fifo_count[1]), 64'd8);
      end
      tick();
      if (rdy) n_acc++;
    end
    req_valid[1] = 1'b0;
    chk("full observed", 64'(full_seen), 64'd1);
    for (int t = 0; t < 400 && issued_count[1] != 16'd12; t++) tick();
    chk("burst issued", 64'(issued_count[1]), 64'd12);
    rises.delete();
    rdata.delete();
    foreach (evq[e]) if (evq[e].inst == 1 && evq[e].rise) begin
      rises.push_back(evq[e].cyc);
      rdata.push_back(evq[e].data);
    end
    chk("burst rise count", 64'(rises.size()), 64'd12);
    for (int j = 0; j < rises.size(); j++) begin
      chk($sformatf("burst order %0d", j), 64'(rdata[j]), 64'(32'h100 + 32'(j)));
      if (j > 0) chk($sformatf("burst period %0d", j), 64'(rises[j] - rises[j-1]), 64'd13);
    end

    // Flush during the first pulse of the 4/4/4 instance.
    apply_reset();
    for (int j = 0; j < 3; j++) begin
      req_valid[1] = 1'b1;
      req_addr[1]  = ctrl_addr_t'(j + 5);
      req_wdata[1] = 32'hA0 + 32'(j);
      tick();
    end
    req_valid[1] = 1'b0;
    for (int t = 0; t < 30 && !wen[1]; t++) tick();
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    w = 1;
    chk("flush empties fifo", 64'(fifo_count[1]), 64'd0);
    chk("flush keeps pulse", 64'(wen[1]), 64'd1);
    while (wen[1] && w < 300) begin
      tick();
      w++;
    end
    chk("flushed pulse width", 64'(w), 64'd4);
    for (int t = 0; t < 40; t++) tick();
    chk("flush issued", 64'(issued_count[1]), 64'd1);
    chk("flush rises", 64'(ev_count(1, 1'b1)), 64'd1);

    // Reset in the middle of a pulse with five entries still queued.
    apply_reset();
    for (int j = 0; j < 6; j++) begin
      req_valid[1] = 1'b1;
      req_addr[1]  = ctrl_addr_t'(10);
      req_wdata[1] = 32'h5A5A_0000 + 32'(j);
      tick();
    end
    req_valid[1] = 1'b0;
    for (int t = 0; t < 30 && !wen[1]; t++) tick();
    chk("queued before rst", 64'(fifo_count[1]), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid enable", 64'(wen[1]), 64'd0);
    chk("rst mid count", 64'(fifo_count[1]), 64'd0);
    chk("rst mid addr", 64'(ctrl_addr[1]), 64'd0);
    chk("rst mid data", 64'(ctrl_wdata[1]), 64'd0);
    chk("rst mid ready", 64'(req_ready[1]), 64'd1);
    evq.delete();
    for (int t = 0; t < 40; t++) tick();
    chk("no pulse after rst", 64'(ev_count(1, 1'b1)), 64'd0);

    // Two back-to-back requests on the 2/3/2 instance.
    apply_reset();
    for (int j = 0; j < 2; j++) begin
      req_valid[2] = 1'b1;
      req_addr[2]  = ctrl_addr_t'(j);
      req_wdata[2] = 32'hC0 + 32'(j);
      tick();
    end
    req_valid[2] = 1'b0;
    for (int t = 0; t < 60 && ev_count(2, 1'b0) < 2; t++) tick();
    rises.delete();
    falls.delete();
    foreach (evq[e]) if (evq[e].inst == 2) begin
      if (evq[e].rise) rises.push_back(evq[e].cyc);
      else falls.push_back(evq[e].cyc);
    end
    chk("b2b rises", 64'(rises.size()), 64'd2);
    chk("b2b falls", 64'(falls.size()), 64'd2);
    if (rises.size() == 2 && falls.size() == 2) begin
      chk("b2b period", 64'(rises[1] - rises[0]), 64'd8);
      chk("b2b width0", 64'(falls[0] - rises[0]), 64'd3);
      chk("b2b width1", 64'(falls[1] - rises[1]), 64'd3);
      chk("b2b low", 64'(rises[1] - falls[0]), 64'd5);
    end

`ifdef CMS_CTRL_SEQ_SHADOW_EN
    apply_reset();
    shadow_raddr[0] = MONITORED_ADDRESS_RANGE_UPPER_BOUND;
    #1 chk("shadow upper reset", 64'(shadow_rdata[0]), 64'hFFFF_FFFF);
    shadow_raddr[0] = TRIGGER_TRACE_END_ADDRESS;
    #1 chk("shadow end reset", 64'(shadow_rdata[0]), 64'hFFFF_FFFF);
    shadow_raddr[0] = CLK_COUNTER;
    #1 chk("shadow clk reset", 64'(shadow_rdata[0]), 64'd0);
    req_valid[0] = 1'b1;
    req_addr[0]  = CLK_COUNTER;
    req_wdata[0] = 32'd5;
    tick();
    req_valid[0] = 1'b0;
    chk("shadow before rise", 64'(shadow_rdata[0]), 64'd0);
    for (int t = 0; t < 20 && !wen[0]; t++) tick();
    chk("shadow at rise", 64'(shadow_rdata[0]), 64'd5);
`endif

    // Random traffic on all three instances against the model.
    apply_reset();
    for (int t = 0; t < 1500; t++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int j = 0; j < N; j++) begin
        req_valid[j] = ($urandom_range(0, 2) != 0);
        flush[j]     = ($urandom_range(0, 39) == 0);
        req_addr[j]  = ctrl_addr_t'($urandom_range(0, 15));
        req_wdata[j] = $urandom;
      end
      tick();
    end
    rst       = 1'b0;
    req_valid = '0;
    flush     = '0;
    for (int t = 0; t < 60; t++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
